// File: rtl/ring_modulator_param_if.sv
// Sample stream and register-write bus for the ring modulator.
// The master drives samples and register writes; the slave returns the modulated stream.
interface ring_modulator_param_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned PW = 24
);
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 wr;
    logic [7:0]           waddr;
    logic [PW-1:0]        wdata;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output wr,
        output waddr,
        output wdata,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  wr,
        input  waddr,
        input  wdata,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/ring_modulator_param.sv
// Ring modulator: each accepted sample is multiplied by a sine carrier from a phase accumulator.
// Define RING_MOD_MIX_EN to add the DEPTH register and a wet/dry mix stage (latency 4 instead of 3).
module ring_modulator_param #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 12,
    parameter int unsigned PW = 24,
    parameter int unsigned LW = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ring_modulator_param_if.slave bus
);
    localparam logic [7:0]  ADDR_INC  = 8'h20;
    localparam logic [7:0]  ADDR_CTRL = 8'h22;
    localparam int unsigned ROM_SIZE  = 2 ** LW;

    localparam logic signed [DW+CW-1:0] PROD_MAX = {{(CW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [DW+CW-1:0] PROD_MIN = {{(CW + 1){1'b1}}, {(DW - 1){1'b0}}};
    localparam logic signed [DW-1:0]    OUT_MAX  = {1'b0, {(DW - 1){1'b1}}};
    localparam logic signed [DW-1:0]    OUT_MIN  = {1'b1, {(DW - 1){1'b0}}};

    function automatic logic signed [CW-1:0] sine_val(input int k);
        real         amp;
        real         x;
        int          v;
        logic [31:0] vb;
        amp = (2.0 ** (CW - 1)) - 1.0;
        x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(ROM_SIZE));
        // Round half away from zero so the table is symmetric about zero.
        if (x >= 0.0) v = $rtoi(x + 0.5);
        else          v = -$rtoi(0.5 - x);
        vb = v;
        return vb[CW-1:0];
    endfunction

    // Constant-argument calls fold into a fixed table at elaboration.
    logic signed [CW-1:0] w_rom [ROM_SIZE];
    for (genvar k = 0; k < ROM_SIZE; k++) begin : g_rom
        assign w_rom[k] = sine_val(k);
    end

    logic          w_wr_inc;
    logic          w_wr_ctrl;
    logic          w_phrst;
    logic [PW-1:0] r_inc;
    logic [PW-1:0] r_phase;
    logic          r_en;

    assign w_wr_inc  = bus.wr && (bus.waddr == ADDR_INC);
    assign w_wr_ctrl = bus.wr && (bus.waddr == ADDR_CTRL);
    assign w_phrst   = w_wr_ctrl && bus.wdata[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inc <= '0;
            r_en  <= 1'b0;
        end else begin
            if (w_wr_inc)  r_inc <= bus.wdata;
            if (w_wr_ctrl) r_en  <= bus.wdata[0];
        end
    end

    // PHRST overrides the advance; a sample in the same cycle still looks up the old phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (w_phrst) begin
            r_phase <= '0;
        end else if (bus.in_valid) begin
            r_phase <= r_phase + r_inc;
        end
    end

`ifdef RING_MOD_MIX_EN
    localparam logic [7:0] ADDR_DEPTH = 8'h21;
    logic       w_wr_depth;
    logic [7:0] r_depth;

    assign w_wr_depth = bus.wr && (bus.waddr == ADDR_DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_depth <= 8'd128;
        end else if (w_wr_depth) begin
            r_depth <= (bus.wdata > PW'(128)) ? 8'd128 : bus.wdata[7:0];
        end
    end
`endif

    // S0: capture the dry sample, the ROM address and the settings that travel with it.
    logic                 r_s0_valid;
    logic                 r_s0_en;
    logic signed [DW-1:0] r_s0_dry;
    logic [LW-1:0]        r_s0_addr;
`ifdef RING_MOD_MIX_EN
    logic [7:0]           r_s0_depth;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s0_valid <= 1'b0;
            r_s0_en    <= 1'b0;
            r_s0_dry   <= '0;
            r_s0_addr  <= '0;
`ifdef RING_MOD_MIX_EN
            r_s0_depth <= 8'd0;
`endif
        end else begin
            r_s0_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s0_en   <= r_en;
                r_s0_dry  <= bus.in_data;
                r_s0_addr <= r_phase[PW-1 -: LW];
`ifdef RING_MOD_MIX_EN
                r_s0_depth <= r_depth;
`endif
            end
        end
    end

    // S1: synchronous ROM read.
    logic                 r_s1_valid;
    logic                 r_s1_en;
    logic signed [DW-1:0] r_s1_dry;
    logic signed [CW-1:0] r_s1_carrier;
`ifdef RING_MOD_MIX_EN
    logic [7:0]           r_s1_depth;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_en      <= 1'b0;
            r_s1_dry     <= '0;
            r_s1_carrier <= '0;
`ifdef RING_MOD_MIX_EN
            r_s1_depth   <= 8'd0;
`endif
        end else begin
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_en      <= r_s0_en;
                r_s1_dry     <= r_s0_dry;
                r_s1_carrier <= w_rom[r_s0_addr];
`ifdef RING_MOD_MIX_EN
                r_s1_depth   <= r_s0_depth;
`endif
            end
        end
    end

    // S2: full-precision product, scaled back by the carrier peak and saturated.
    logic signed [DW+CW-1:0] w_prod;
    logic signed [DW+CW-1:0] w_prod_sh;
    logic signed [DW-1:0]    w_wet;
    logic signed [DW-1:0]    w_s2_sel;

    always_comb begin
        w_prod    = $signed({{CW{r_s1_dry[DW-1]}}, r_s1_dry})
                  * $signed({{DW{r_s1_carrier[CW-1]}}, r_s1_carrier});
        w_prod_sh = w_prod >>> (CW - 1);
        if (w_prod_sh > PROD_MAX)      w_wet = OUT_MAX;
        else if (w_prod_sh < PROD_MIN) w_wet = OUT_MIN;
        else                           w_wet = w_prod_sh[DW-1:0];
        w_s2_sel  = r_s1_en ? w_wet : r_s1_dry;
    end

    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_data;

`ifdef RING_MOD_MIX_EN
    localparam int unsigned MW = DW + 10;
    localparam logic signed [MW-1:0] MIX_MAX = {{11{1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [MW-1:0] MIX_MIN = {{11{1'b1}}, {(DW - 1){1'b0}}};

    // In bypass the wet slot carries dry, so the mix below reduces to dry for any depth.
    logic                 r_s2_valid;
    logic signed [DW-1:0] r_s2_dry;
    logic signed [DW-1:0] r_s2_wet;
    logic [7:0]           r_s2_depth;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_dry   <= '0;
            r_s2_wet   <= '0;
            r_s2_depth <= 8'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_dry   <= r_s1_dry;
                r_s2_wet   <= w_s2_sel;
                r_s2_depth <= r_s1_depth;
            end
        end
    end

    // S3: out = dry + ((wet - dry) * depth) >>> 7, saturated.
    logic signed [DW:0]   w_diff;
    logic signed [MW-1:0] w_mix_prod;
    logic signed [MW-1:0] w_mix_sum;
    logic signed [DW-1:0] w_mix;

    always_comb begin
        w_diff     = $signed({r_s2_wet[DW-1], r_s2_wet}) - $signed({r_s2_dry[DW-1], r_s2_dry});
        w_mix_prod = $signed({{9{w_diff[DW]}}, w_diff}) * $signed({{(MW - 8){1'b0}}, r_s2_depth});
        w_mix_sum  = $signed({{10{r_s2_dry[DW-1]}}, r_s2_dry}) + (w_mix_prod >>> 7);
        if (w_mix_sum > MIX_MAX)      w_mix = OUT_MAX;
        else if (w_mix_sum < MIX_MIN) w_mix = OUT_MIN;
        else                          w_mix = w_mix_sum[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) r_out_data <= w_mix;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) r_out_data <= w_s2_sel;
        end
    end
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: doc/ring_modulator_param.md
# ring_modulator_param

Parametrised ring modulator for the audio effect chain. Multiplies each incoming signed audio sample by an internally generated sine carrier. The carrier comes from a phase accumulator plus a sine ROM, and it advances once per accepted sample. Carrier frequency, wet/dry depth, enable and phase reset are programmed through the existing register-write bus (phase increment at 0x20). The block sits between the delay/gain stages and the output formatter, and replaces the fixed-width, fixed-frequency ring modulator.

## Interface
- DW, 16: audio sample width, signed two's complement.
- CW, 12: carrier amplitude width, signed; ROM peak is ±(2^(CW-1)-1).
- PW, 24: phase accumulator width.
- LW, 8: sine ROM address width (2^LW entries, full wave).
- clk  in  1  system clock.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  sample strobe (for example once per 48 kHz frame). No backpressure.
- in_data  in  DW  signed audio sample, sampled when in_valid=1.
- wr  in  1  register write strobe, single cycle.
- waddr  in  8  register address.
- wdata  in  PW  register write data (LSB-aligned).
- out_valid  out  1  output strobe, one cycle per accepted sample.
- out_data  out  DW  signed modulated sample.

## Operation
- Registers, all written when wr=1. Unmapped addresses are ignored. Writes to these addresses have no effect on the data path:
  - 0x20 INC[PW-1:0]: phase increment. Reset value 0.
  - 0x21 DEPTH[7:0]: wet amount, 0..128. Values above 128 are clamped to 128 on write. Reset value 128.
  - 0x22 CTRL:
    - bit0 EN: reset value 0, meaning bypass.
    - bit1 PHRST: self-clearing. Writing 1 clears the accumulator.
- Sine ROM contents: ROM[k] = round((2^(CW-1)-1)·sin(2πk/2^LW)), computed at elaboration. The ROM is a synchronous read.
- Pipeline, one new sample accepted per cycle at most:
  - S0, on in_valid:
    - Latch in_data as dry.
    - ROM address = PHASE[PW-1 -: LW].
    - PHASE <= PHASE + INC, modulo 2^PW.
  - S1: carrier = ROM[addr]. dry is carried along.
  - S2: wet = (dry·carrier) >>> (CW-1), using an arithmetic shift. The product is DW+CW bits signed. Saturate to DW bits.
  - S3 (only when RING_MOD_MIX_EN is defined): out = dry + (((wet-dry)·DEPTH) >>> 7), saturated to DW bits.
- EN=0: out_data equals dry, with unchanged latency and valid timing. The accumulator keeps advancing, so re-enabling does not cause a phase jump.
- A valid strobe travels alongside the data. out_valid = in_valid delayed by the pipeline latency.

## Timing
- Latency from in_valid to out_valid:
  - 3 cycles without RING_MOD_MIX_EN.
  - 4 cycles with RING_MOD_MIX_EN.
- Back-to-back in_valid every cycle is supported at full throughput.
- While reset_n=0:
  - out_valid=0, out_data=0, PHASE=0.
  - INC=0, DEPTH=128, EN=0.
  - All pipeline valids are cleared.
- Reset asserted mid-stream: in-flight samples are discarded and no out_valid is produced for them.
- A write to INC in the same cycle as in_valid: that sample advances PHASE with the old INC. The new INC applies from the next accepted sample.
- A PHRST write in the same cycle as in_valid: the sample uses the current PHASE for lookup. PHASE then becomes 0, not PHASE+INC.
- A write to EN or DEPTH takes effect for samples entering S0 after the write cycle. Samples already in flight use the settings captured at S0.
- INC=0 freezes the carrier at its current phase.
- PHASE wrap-around at 2^PW is silent.

## Configuration
- RING_MOD_MIX_EN defined:
  - DEPTH register and stage S3 are present.
  - Latency is 4.
  - DEPTH=0 gives dry, DEPTH=128 gives pure wet.
- RING_MOD_MIX_EN undefined:
  - No DEPTH register; writes to 0x21 are ignored.
  - Output is pure wet when EN=1.
  - Latency is 3.

## Test plan
All scenarios use default parameters.

1. Reset: hold reset_n=0 with in_valid toggling. Required: out_valid=0 and out_data=0 throughout. Release reset, send a sample of 0x1234 with EN=0. Required: out_data=0x1234 exactly at the stated latency.
2. Quarter-wave carrier: set EN=1 and INC=0x400000 (ROM address steps of 64). Send four samples of 0x4000. Required: out_data sequence 0, 16376, 0, -16376 (DEPTH=128 in the mix build).
3. Mix (mix build only): setup as in scenario 2, then set DEPTH=64. The second sample gives out = 16384 + ((16376-16384)·64 >>> 7) = 16380. Also write DEPTH=200 and confirm it reads back as behaviour equal to 128.
4. Phase reset and same-cycle events: mid-stream, issue a PHRST write in the same cycle as an in_valid. Required: that sample uses the old phase, and the next sample uses ROM[0], giving out=0. An INC write together with in_valid takes effect one sample later.
5. Throughput and mid-stream reset: drive in_valid every cycle for 100 cycles. Required: 100 out_valid pulses with no gaps. Assert reset_n during the burst. Required: no further out_valid, and PHASE restarts from 0.
6. Saturation: with EN=1, carrier at -2047 and in_data=-32768. Required: wet = 32752 with no overflow. With the mix build and DEPTH=0, out equals dry.
